uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, the number of data bits per frame (legal 5..9).
REQ-002 SHALL provide parameter PARITY, default 0, the parity mode (0 none, 1 odd, 2 even).
REQ-003 SHALL provide parameter STOP_BITS, default 1, the number of stop bits (legal 1 or 2).
REQ-004 SHALL provide parameter OVERSAMPLE, default 16, the number of sample_tick pulses per bit (even, legal 8..64).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-007 SHALL have port rx_serial, input, 1, the asynchronous serial line, which idles high.
REQ-008 SHALL have port sample_tick, input, 1, a one-clk pulse at OVERSAMPLE x baud rate.
REQ-009 SHALL have port rd_ready, input, 1, the consumer accept signal.
REQ-010 SHALL have port data_out, output, DATA_BITS, the received data, LSB first on the line.
REQ-011 SHALL have port rx_valid, output, 1, asserted when data_out holds an unread frame.
REQ-012 SHALL have port parity_err, output, 1, the parity status of the frame in data_out.
REQ-013 SHALL have port frame_err, output, 1, the stop-bit status of the frame in data_out.
REQ-014 SHALL have port overrun, output, 1, a sticky flag for a frame lost to a full output register.
REQ-015 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 SHALL pass rx_serial through a 2-flop synchronizer whose flops reset to 1; all sampling uses the synchronized value.
REQ-017 SHALL have FSM states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-018 SHALL leave IDLE for START when a sample_tick arrives with the line low, and clear the tick counter.
REQ-019 SHALL, in START, sample the line at tick count OVERSAMPLE/2-1; if the line is high it is a false start and the FSM returns to IDLE with no output change.
REQ-020 SHALL, in START, go to DATA if the mid-bit sample is low.
REQ-021 SHALL, in DATA, PARITY and STOP, sample once every OVERSAMPLE ticks, counted from the start-bit mid sample, so that every sample falls mid-bit.
REQ-022 SHALL shift data in LSB first and leave DATA after DATA_BITS samples, going to PARITY if PARITY!=0, otherwise to STOP.
REQ-023 SHALL set the parity error when the XOR of the data bits and the parity bit is 0 in odd mode or 1 in even mode.
REQ-024 SHALL, in STOP, take STOP_BITS samples and set the frame error if any of them is low.
REQ-025 SHALL, on the clk after the last stop sample, load data_out, parity_err and frame_err and set rx_valid=1; this load is the frame delivery.
REQ-026 SHALL deliver frames that have errors, with the corresponding error flag set.
REQ-027 SHALL, after the last stop sample, go to IDLE if that sample was high, otherwise to WAIT_HIGH.
REQ-028 SHALL hold WAIT_HIGH until the line is sampled high on a sample_tick, then go to IDLE; this covers break conditions.
REQ-029 SHALL complete a handshake when rx_valid && rd_ready; the handshake clears rx_valid and overrun on the next clk.
REQ-030 SHALL, if a delivery occurs while rx_valid=1 and rd_ready=0, drop the new frame, keep data_out unchanged and set overrun=1.
REQ-031 SHALL, if a delivery coincides with a handshake, load the new frame, keep rx_valid=1 and leave overrun=0.
REQ-032 SHALL ignore sample_tick pulses only for counting purposes and never modify data_out except on delivery.

Reset
REQ-033 SHALL, while rst_n=0, force state=IDLE, all counters to 0, synchronizer flops to 1, data_out=0, and rx_valid=parity_err=frame_err=overrun=busy=0, asynchronously.
REQ-034 SHALL, on reset asserted mid-frame, discard the partial frame; after release the block waits for a fresh falling edge.

Verification
REQ-035 SHALL cover: 8N1, OVERSAMPLE=16, frame 0xA5 -> data_out=0xA5, rx_valid=1 one clk after the stop mid-sample, both error flags 0.
REQ-036 SHALL cover: PARITY=2, 0x3C sent with parity bit 1 -> data_out=0x3C, parity_err=1; the same frame with parity bit 0 -> parity_err=0.
REQ-037 SHALL cover: 0x55 with the stop bit low, line held low for 20 bit times -> frame_err=1, FSM in WAIT_HIGH, no second frame until the line returns high.
REQ-038 SHALL cover: a low glitch of 4 ticks -> no delivery, FSM back to IDLE, busy low.
REQ-039 SHALL cover: 0x11 then 0x22 with rd_ready=0 -> data_out=0x11, overrun=1; one rd_ready pulse -> rx_valid=0, overrun=0.
REQ-040 SHALL cover: rst_n pulsed low during data bit 3 -> all outputs 0; the next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable data bits, parity and stop bits.
// One-deep output register with a ready/valid handshake and a sticky overrun flag.
module uart_rx_cfg #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_serial,
   input  logic                 sample_tick,
   input  logic                 rd_ready,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_PARITY    = 3'd3;
   localparam logic [2:0] S_STOP      = 3'd4;
   localparam logic [2:0] S_WAIT_HIGH = 3'd5;

   logic [2:0]           state;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bcnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr_q, ferr_q, dlv;
   logic                 rx_s1, rx_s2;

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         bcnt       <= '0;
         shreg      <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         dlv        <= 1'b0;
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         data_out   <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         rx_s1 <= rx_serial;
         rx_s2 <= rx_s1;
         dlv   <= 1'b0;

         if (sample_tick) begin
            case (state)
               S_IDLE: if (!rx_s2) begin
                  state <= S_START;
                  cnt   <= '0;
               end
               // Half a bit after the falling edge; a high line here is a glitch.
               S_START: if (cnt == HALF_M1) begin
                  cnt    <= '0;
                  bcnt   <= '0;
                  perr_q <= 1'b0;
                  ferr_q <= 1'b0;
                  state  <= rx_s2 ? S_IDLE : S_DATA;
               end else cnt <= cnt + 1'b1;
               S_DATA: if (cnt == FULL_M1) begin
                  cnt   <= '0;
                  shreg <= {rx_s2, shreg[DATA_BITS-1:1]};
                  if (bcnt == LAST_DATA) begin
                     bcnt  <= '0;
                     state <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else bcnt <= bcnt + 1'b1;
               end else cnt <= cnt + 1'b1;
               S_PARITY: if (cnt == FULL_M1) begin
                  cnt    <= '0;
                  perr_q <= (PARITY == 1) ? ~(^shreg ^ rx_s2) : (^shreg ^ rx_s2);
                  state  <= S_STOP;
               end else cnt <= cnt + 1'b1;
               S_STOP: if (cnt == FULL_M1) begin
                  cnt <= '0;
                  if (!rx_s2) ferr_q <= 1'b1;
                  if (bcnt == LAST_STOP) begin
                     bcnt  <= '0;
                     dlv   <= 1'b1;
                     state <= rx_s2 ? S_IDLE : S_WAIT_HIGH;
                  end else bcnt <= bcnt + 1'b1;
               end else cnt <= cnt + 1'b1;
               S_WAIT_HIGH: if (rx_s2) state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end

         // A frame landing on a full, unaccepted register is dropped.
         if (dlv) begin
            if (!rx_valid || rd_ready) begin
               data_out   <= shreg;
               parity_err <= perr_q;
               frame_err  <= ferr_q;
               rx_valid   <= 1'b1;
               overrun    <= 1'b0;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rd_ready) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
      end
   end

endmodule
